// File: rtl/am_pwm_modulator_pkg.sv
// Shared definitions for the AM/PWM modulator: output mode encodings and
// default parameter values used by the modulator and its timebase.
package am_pwm_modulator_pkg;

    // Output mode encodings presented on the mode input.
    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_PWM = 2'd1;
    localparam logic [1:0] MODE_AM  = 2'd2;
    localparam logic [1:0] MODE_OOK = 2'd3;

    // Default parameter values for the modulator.
    localparam int AMPWM_DATA_W        = 8;
    localparam int AMPWM_PWM_STEPS     = 256;
    localparam int AMPWM_CLKS_PER_STEP = 1;
    localparam int AMPWM_CARRIER_DIV   = 4;

endpackage

// File: rtl/am_pwm_modulator_timebase.sv
// PWM timebase: prescaler plus duty-step counter. o_boundary is high while
// both counters sit at zero, i.e. on the clock that opens a new PWM period.
module pwm_timebase #(
    parameter int PWM_STEPS     = 16,
    parameter int CLKS_PER_STEP = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    output logic [$clog2(PWM_STEPS)-1:0] o_step,
    output logic                         o_boundary
);

    localparam int STEP_W = $clog2(PWM_STEPS);
    localparam int PRE_W  = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLKS_PER_STEP - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(PWM_STEPS - 1);

    logic [PRE_W-1:0]  r_presc;
    logic [STEP_W-1:0] r_step;
    logic              w_presc_wrap;

    assign w_presc_wrap = (r_presc == PRE_LAST);

    // Prescaler: counts 0..CLKS_PER_STEP-1 and wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_presc <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Step counter: advances on prescaler wrap, counts 0..PWM_STEPS-1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_step <= '0;
        end else if (w_presc_wrap) begin
            r_step <= (r_step == STEP_LAST) ? '0 : r_step + 1'b1;
        end
    end

    assign o_step     = r_step;
    assign o_boundary = (r_presc == '0) && (r_step == '0);

endmodule

// File: rtl/am_pwm_modulator.sv
// AM/PWM modulator: takes one duty sample per PWM period through a one-entry
// holding register and drives a registered output that is off, plain PWM,
// PWM window gated by a free-running carrier (AM), or carrier keyed on/off
// for the whole period (OOK).
module am_pwm_modulator
    import am_pwm_modulator_pkg::*;
#(
    parameter int DATA_W        = AMPWM_DATA_W,
    parameter int PWM_STEPS     = AMPWM_PWM_STEPS,
    parameter int CLKS_PER_STEP = AMPWM_CLKS_PER_STEP,
    parameter int CARRIER_DIV   = AMPWM_CARRIER_DIV
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] sample_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              pwm,
    output logic              period_start,
    output logic              underrun
);

    localparam int STEP_W = $clog2(PWM_STEPS);
    localparam int DUTY_W = DATA_W + 1;
    localparam int CAR_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
    localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(PWM_STEPS);
    localparam logic [CAR_W-1:0]  CAR_LAST  = CAR_W'(CARRIER_DIV - 1);

    // Saturate a raw sample to the number of steps in a period.
    function automatic logic [DUTY_W-1:0] f_sat_duty(input logic [DATA_W-1:0] i_val);
        logic [DUTY_W-1:0] v;
        v = {1'b0, i_val};
        f_sat_duty = (v >= DUTY_FULL) ? DUTY_FULL : v;
    endfunction

    logic [STEP_W-1:0] w_step;
    logic              w_boundary;
    logic              w_accept;
    logic              w_load;
    logic              w_hold_full_nxt;
    logic [DUTY_W-1:0] w_duty_nxt;
    logic [1:0]        w_mode_nxt;
    logic              w_window_p0;
    logic              w_pwm_p0;

    logic              r_hold_full;
    logic [DATA_W-1:0] r_hold_data;
    logic              r_ready;
    logic              r_first;
    logic [DUTY_W-1:0] r_duty;
    logic [1:0]        r_mode;
    logic [CAR_W-1:0]  r_car_cnt;
    logic              r_carrier;
    logic              r_pwm;
    logic              r_period_start;
    logic              r_underrun;

    pwm_timebase #(
        .PWM_STEPS     (PWM_STEPS),
        .CLKS_PER_STEP (CLKS_PER_STEP)
    ) u_timebase (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .o_step     (w_step),
        .o_boundary (w_boundary)
    );

    assign w_accept        = sample_valid & r_ready;
    assign w_load          = w_boundary & r_hold_full;
    assign w_hold_full_nxt = (r_hold_full & ~w_load) | w_accept;

    // Settings that take effect on this clock: on a boundary the new duty and
    // mode already drive the output term, so the registered pwm lines up with
    // period_start on the first clock of the period.
    assign w_duty_nxt  = w_load ? f_sat_duty(r_hold_data) : r_duty;
    assign w_mode_nxt  = w_boundary ? mode : r_mode;
    assign w_window_p0 = (DUTY_W'(w_step) < w_duty_nxt);

    // Select the output term for the active mode.
    always_comb begin
        w_pwm_p0 = 1'b0;
        case (w_mode_nxt)
            MODE_PWM: w_pwm_p0 = w_window_p0;
            MODE_AM:  w_pwm_p0 = w_window_p0 & r_carrier;
            MODE_OOK: w_pwm_p0 = (w_duty_nxt != '0) & r_carrier;
            default:  w_pwm_p0 = 1'b0;
        endcase
    end

    // Holding-register occupancy and the registered ready flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_full <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_hold_full <= w_hold_full_nxt;
            r_ready     <= ~w_hold_full_nxt;
        end
    end

    // Holding-register payload; only meaningful while r_hold_full is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_hold_data <= sample_data;
        end
    end

    // Active duty/mode, plus the flag that suppresses underrun on the first boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_duty  <= '0;
            r_mode  <= MODE_OFF;
            r_first <= 1'b1;
        end else begin
            r_duty  <= w_duty_nxt;
            r_mode  <= w_mode_nxt;
            r_first <= 1'b0;
        end
    end

    // Free-running carrier, toggling every CARRIER_DIV clocks, never resynchronised.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_car_cnt <= '0;
            r_carrier <= 1'b0;
        end else if (r_car_cnt == CAR_LAST) begin
            r_car_cnt <= '0;
            r_carrier <= ~r_carrier;
        end else begin
            r_car_cnt <= r_car_cnt + 1'b1;
        end
    end

    // Registered outputs: modulated pwm and the per-period status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pwm          <= 1'b0;
            r_period_start <= 1'b0;
            r_underrun     <= 1'b0;
        end else begin
            r_pwm          <= w_pwm_p0;
            r_period_start <= w_boundary;
            r_underrun     <= w_boundary & ~r_hold_full & ~r_first;
        end
    end

    assign sample_ready = r_ready;
    assign pwm          = r_pwm;
    assign period_start = r_period_start;
    assign underrun     = r_underrun;

endmodule
